// File: rtl/led_pwm_engine.sv
// Multi-channel LED PWM engine with off/static/blink/breathe modes.
// Channel settings arrive through a single pending slot and commit on PWM frame boundaries.
module led_pwm_engine #(
    parameter int NUM_CH      = 3,
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 98,
    parameter int PERIOD_BITS = 8,
    localparam int CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CH_BITS-1:0]     cfg_ch,
    input  logic [1:0]             cfg_mode,
    input  logic [PWM_BITS-1:0]    cfg_level,
    input  logic [PERIOD_BITS-1:0] cfg_period,
    output logic [NUM_CH-1:0]      led_out,
    output logic                   frame_strobe
);

    localparam int PS_BITS = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PWM_BITS-1:0] ONES = {PWM_BITS{1'b1}};
    localparam logic [CH_BITS:0] NUM_CH_W = (CH_BITS + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    logic [PS_BITS-1:0]     presc;
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic                   tick;
    logic                   frame_end;
    logic                   ch_ok;

    logic                   pend_valid;
    logic [CH_BITS-1:0]     pend_ch;
    mode_t                  pend_mode;
    logic [PWM_BITS-1:0]    pend_level;
    logic [PERIOD_BITS-1:0] pend_period;

    mode_t                  mode_q   [NUM_CH];
    logic [PWM_BITS-1:0]    level_q  [NUM_CH];
    logic [PERIOD_BITS-1:0] period_q [NUM_CH];
    logic [PERIOD_BITS-1:0] fcnt_q   [NUM_CH];
    logic                   phase_q  [NUM_CH];
    logic [PWM_BITS-1:0]    br_q     [NUM_CH];
    logic                   down_q   [NUM_CH];
    logic [PWM_BITS-1:0]    eff      [NUM_CH];

    assign tick      = (presc == PS_BITS'(PRESCALE - 1));
    assign frame_end = tick && (pwm_cnt == ONES);
    assign cfg_ready = ~pend_valid;
    assign ch_ok     = ({1'b0, cfg_ch} < NUM_CH_W);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eff[i] = '0;
            case (mode_q[i])
                MODE_STATIC:  eff[i] = level_q[i];
                MODE_BLINK:   eff[i] = phase_q[i] ? '0 : level_q[i];
                MODE_BREATHE: eff[i] = br_q[i];
                default:      eff[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc        <= '0;
            pwm_cnt      <= '0;
            frame_strobe <= 1'b0;
            led_out      <= '0;
            pend_valid   <= 1'b0;
            pend_ch      <= '0;
            pend_mode    <= MODE_OFF;
            pend_level   <= '0;
            pend_period  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]   <= MODE_OFF;
                level_q[i]  <= '0;
                period_q[i] <= '0;
                fcnt_q[i]   <= '0;
                phase_q[i]  <= 1'b0;
                br_q[i]     <= '0;
                down_q[i]   <= 1'b0;
            end
        end else begin
            presc        <= tick ? '0 : presc + PS_BITS'(1);
            frame_strobe <= frame_end;
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end

            // Out-of-range channels are consumed without occupying the slot.
            if (cfg_valid && cfg_ready && ch_ok) begin
                pend_valid  <= 1'b1;
                pend_ch     <= cfg_ch;
                pend_mode   <= mode_t'(cfg_mode);
                pend_level  <= cfg_level;
                pend_period <= cfg_period;
            end else if (frame_end && pend_valid) begin
                pend_valid <= 1'b0;
            end

            for (int i = 0; i < NUM_CH; i++) begin
                led_out[i] <= (eff[i] == ONES) ? 1'b1 : (pwm_cnt < eff[i]);
                if (frame_end) begin
                    if (pend_valid && pend_ch == CH_BITS'(i)) begin
                        mode_q[i]   <= pend_mode;
                        level_q[i]  <= pend_level;
                        period_q[i] <= pend_period;
                        fcnt_q[i]   <= '0;
                        phase_q[i]  <= 1'b0;
                        br_q[i]     <= '0;
                        down_q[i]   <= 1'b0;
                    end else if (fcnt_q[i] == period_q[i]) begin
                        fcnt_q[i] <= '0;
                        if (mode_q[i] == MODE_BLINK) begin
                            phase_q[i] <= ~phase_q[i];
                        end else if (mode_q[i] == MODE_BREATHE) begin
                            // Triangle ramp between 0 and level, one step per event.
                            if (!down_q[i]) begin
                                if (br_q[i] >= level_q[i]) begin
                                    down_q[i] <= 1'b1;
                                    br_q[i]   <= (br_q[i] == '0) ? '0 : br_q[i] - PWM_BITS'(1);
                                end else begin
                                    br_q[i] <= br_q[i] + PWM_BITS'(1);
                                end
                            end else begin
                                if (br_q[i] == '0) begin
                                    down_q[i] <= 1'b0;
                                    br_q[i]   <= (level_q[i] != '0) ? PWM_BITS'(1) : '0;
                                end else begin
                                    br_q[i] <= br_q[i] - PWM_BITS'(1);
                                end
                            end
                        end
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + PERIOD_BITS'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_engine.sv
// Directed bench for led_pwm_engine: PRESCALE=2, PWM_BITS=4, NUM_CH=3 (32-cycle frame).
module tb_led_pwm_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [3:0] cfg_level = '0;
    logic [7:0] cfg_period = '0;
    logic [2:0] led_out;
    logic       frame_strobe;

    int checks = 0;
    int passed = 0;
    logic [5:0] exp_q[$];

    led_pwm_engine #(
        .NUM_CH(3), .PWM_BITS(4), .PRESCALE(2), .PERIOD_BITS(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_level(cfg_level), .cfg_period(cfg_period),
        .led_out(led_out), .frame_strobe(frame_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Waits for a strobe cycle (inclusive of now), then counts high cycles over one frame.
    task automatic measure(output int h0, output int h1, output int h2);
        int n = 0;
        while (!frame_strobe && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("strobe_seen", int'(frame_strobe), 1);
        h0 = 0; h1 = 0; h2 = 0;
        repeat (32) begin
            @(negedge clk);
            h0 += int'(led_out[0]);
            h1 += int'(led_out[1]);
            h2 += int'(led_out[2]);
        end
    endtask

    task automatic send_cfg(input int ch, input int mode, input int level, input int period);
        int n = 0;
        cfg_ch     = 2'(ch);
        cfg_mode   = 2'(mode);
        cfg_level  = 4'(level);
        cfg_period = 8'(period);
        cfg_valid  = 1'b1;
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cfg_ready_wait", int'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, h0, h1, h2;

        repeat (3) @(negedge clk);
        check("rst_led", int'(led_out), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_strobe", int'(frame_strobe), 0);

        reset = 1'b0;
        n = 1;
        while (!frame_strobe && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("first_strobe_cycle", n, 33);
        @(negedge clk);
        check("strobe_one_cycle", int'(frame_strobe), 0);

        send_cfg(0, 1, 4, 0);
        check("ready_low_pending", int'(cfg_ready), 0);
        measure(h0, h1, h2);
        check("static4_f1", h0, 8);
        check("ready_after_commit", int'(cfg_ready), 1);
        measure(h0, h1, h2);
        check("static4_f2", h0, 8);
        send_cfg(0, 1, 15, 0);
        measure(h0, h1, h2);
        check("static15", h0, 32);
        send_cfg(0, 1, 0, 0);
        measure(h0, h1, h2);
        check("static0", h0, 0);
        send_cfg(0, 1, 4, 0);
        measure(h0, h1, h2);
        check("static4_again", h0, 8);

        send_cfg(1, 2, 8, 1);
        exp_q = {6'd16, 6'd16, 6'd0, 6'd0, 6'd16, 6'd16};
        while (exp_q.size() > 0) begin
            measure(h0, h1, h2);
            check("blink_ch1", h1, int'(exp_q.pop_front()));
            check("blink_ch0_kept", h0, 8);
        end

        send_cfg(2, 3, 3, 0);
        exp_q = {6'd0, 6'd2, 6'd4, 6'd6, 6'd4, 6'd2, 6'd0, 6'd2};
        while (exp_q.size() > 0) begin
            measure(h0, h1, h2);
            check("breathe3_ch2", h2, int'(exp_q.pop_front()));
        end
        send_cfg(2, 3, 5, 0);
        exp_q = {6'd0, 6'd2, 6'd4};
        while (exp_q.size() > 0) begin
            measure(h0, h1, h2);
            check("breathe5_restart", h2, int'(exp_q.pop_front()));
        end

        // Second request is held while the slot is busy.
        send_cfg(0, 1, 15, 0);
        check("pending_a", int'(cfg_ready), 0);
        cfg_ch = 2'd0; cfg_mode = 2'd1; cfg_level = 4'd2; cfg_period = 8'd0;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("held_until_commit", int'(cfg_ready), 1);
        check("ready_on_strobe", int'(frame_strobe), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("b_accepted", int'(cfg_ready), 0);
        repeat (19) @(negedge clk);
        check("a_in_effect", int'(led_out[0]), 1);
        measure(h0, h1, h2);
        check("b_committed", h0, 4);

        // Accept on the frame_end cycle.
        repeat (31) @(negedge clk);
        check("pre_frame_end", int'(frame_strobe), 0);
        cfg_ch = 2'd0; cfg_mode = 2'd1; cfg_level = 4'd8; cfg_period = 8'd0;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("accept_at_frame_end", int'(frame_strobe), 1);
        check("accept_fe_pending", int'(cfg_ready), 0);
        measure(h0, h1, h2);
        check("fe_accept_not_yet", h0, 4);
        measure(h0, h1, h2);
        check("fe_accept_committed", h0, 16);

        send_cfg(3, 1, 15, 0);
        check("bad_ch_ready", int'(cfg_ready), 1);
        measure(h0, h1, h2);
        check("bad_ch_f1", h0, 16);
        measure(h0, h1, h2);
        check("bad_ch_f2", h0, 16);

        // Reset mid-frame with an update pending.
        send_cfg(0, 1, 15, 0);
        check("pending_before_reset", int'(cfg_ready), 0);
        repeat (3) @(negedge clk);
        check("led_high_before_reset", int'(led_out[0]), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_led", int'(led_out), 0);
        check("mid_rst_strobe", int'(frame_strobe), 0);
        check("mid_rst_ready", int'(cfg_ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        measure(h0, h1, h2);
        check("post_rst_ch0", h0, 0);
        check("post_rst_ch1", h1, 0);
        check("post_rst_ch2", h2, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/led_pwm_engine.md
Name: led_pwm_engine

Overview:
- Parametrised successor to the free-running divide-down LED blinker.
- Drives NUM_CH LED outputs with per-channel PWM brightness and four modes: off, static, blink and breathe.
- Runs on the 25 MHz board oscillator domain.
- Per-channel settings are loaded through a valid/ready config port and take effect only at PWM frame boundaries, so the outputs never glitch mid-frame.

Parameters:
- NUM_CH, 3: number of LED channels (R, G, B on the current board).
- PWM_BITS, 8: PWM counter width; one frame is 2^PWM_BITS ticks.
- PRESCALE, 98: clk cycles per PWM tick, must be >= 1 (25 MHz / 98 / 256 ≈ 1 kHz frame rate).
- PERIOD_BITS, 8: width of the per-channel frame-divider setting.

Ports:
- clk  in  1  25 MHz oscillator clock.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config slot free.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_mode  in  2  0 OFF, 1 STATIC, 2 BLINK, 3 BREATHE.
- cfg_level  in  PWM_BITS  brightness / peak duty.
- cfg_period  in  PERIOD_BITS  frames per blink half-phase or breathe step, minus 1.
- led_out  out  NUM_CH  PWM outputs, registered.
- frame_strobe  out  1  one-cycle pulse per frame.

Behaviour:
- Reset (sync, active-high): forces all of the following, including mid-frame and with an update pending. The pending update is discarded; no partial state survives.
  - led_out=0, frame_strobe=0, cfg_ready=1.
  - Prescaler=0, pwm_cnt=0.
  - All channels: mode OFF, level 0, period 0, fcnt 0, phase 0, br 0, dir up.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - tick is asserted on the cycle the prescaler equals PRESCALE-1; the prescaler wraps to 0 on the same cycle.
- pwm_cnt:
  - Increments on tick and wraps 2^PWM_BITS-1 -> 0.
  - frame_end = tick && pwm_cnt == all-ones.
  - frame_strobe is the registered copy of frame_end (one cycle later).
- Effective duty eff per channel:
  - OFF: 0.
  - STATIC: level.
  - BLINK: phase ? 0 : level.
  - BREATHE: br.
- Output compare:
  - led_out[i] <= (eff == all-ones) ? 1 : (pwm_cnt < eff). One cycle latency from pwm_cnt.
  - eff = 0 gives a constant 0.
  - eff = all-ones gives a constant 1.
- Channel step event: on frame_end with fcnt == period, fcnt -> 0; otherwise on frame_end fcnt increments.
  - BLINK: on a step event, phase toggles.
  - BREATHE, dir up, on a step event:
    - br >= level: dir -> down, br -> br-1 (saturating at 0).
    - otherwise: br+1.
  - BREATHE, dir down, on a step event:
    - br == 0: dir -> up, br -> (level > 0 ? 1 : 0).
    - otherwise: br-1.
  - Resulting sequence for level 3: 0,1,2,3,2,1,0,1,…
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready. The fields are captured into a single pending slot and cfg_ready drops the next cycle.
  - On the next frame_end, the pending fields are written to channel cfg_ch, and that channel's fcnt, phase and br clear to 0 with dir up. cfg_ready returns to 1 the cycle after.
  - A transfer accepted on the same cycle as a frame_end commits at the following frame_end, not the current one.
  - cfg_ch >= NUM_CH: accepted, nothing committed, cfg_ready stays 1.
  - cfg_valid while cfg_ready=0 is ignored; the master must hold its request.
  - Other channels are unaffected by a commit; their counters keep running.
- Width rules: all counters wrap modulo their width; no other overflow is possible.

Test Plan (PRESCALE=2, PWM_BITS=4, NUM_CH=3; frame = 32 clk):
- Reset release -> led_out=000, cfg_ready=1, first frame_strobe 33 cycles after reset deasserts.
- STATIC ch0 level 4 -> after commit at the frame boundary, led_out[0] high exactly 8 of 32 cycles per frame; level 15 -> constant 1; level 0 -> constant 0.
- BLINK ch1 level 8 period 1 -> 2 frames at 50 % duty, then 2 frames at 0, repeating; ch0 output unchanged throughout.
- BREATHE ch2 level 3 period 0 -> per-frame high count sequence 0,2,4,6,4,2,0,2 cycles; reprogramming level mid-ramp restarts from br=0.
- Handshake:
  - Second cfg_valid while pending -> cfg_ready=0 and the request is held until the frame after the commit.
  - Accept on the frame_end cycle -> commit one frame later.
  - cfg_ch=3 -> dropped, cfg_ready stays 1.
- Reset asserted mid-frame with an update pending -> all outputs 0 on the next cycle, the pending update is lost, and cfg_ready=1.
